// File: rtl/hdmi_data_island_decoder.sv
// ============================================================================
// hdmi_data_island_decoder: reassembles TERC4-decoded data-island nibbles into
// HDMI packets, checks BCH parity, tracks syncs and latches ACR CTS/N.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hdmi_data_island_decoder #(
    parameter bit         ACR_REQUIRE_ECC = 1'b1,
    parameter logic [7:0] HDR_TYPE_ACR    = 8'h01
) (
    input  logic        i_pixclk,
    input  logic        i_reset,
    input  logic        i_data,
    input  logic [3:0]  i_d0,
    input  logic [3:0]  i_d1,
    input  logic [3:0]  i_d2,
    output logic        o_hSync,
    output logic        o_vSync,
    output logic        o_pkt_valid,
    output logic        o_pkt_first,
    output logic [23:0] o_hdr,
    output logic [55:0] o_sub0,
    output logic [55:0] o_sub1,
    output logic [55:0] o_sub2,
    output logic [55:0] o_sub3,
    output logic        o_hdr_err,
    output logic [3:0]  o_sub_err,
    output logic        o_frame_err,
    output logic [19:0] o_cts,
    output logic [19:0] o_n
);

    function automatic logic [7:0] bch_step(input logic [7:0] code, input logic b);
        bch_step = {code[6:0], 1'b0} ^ ((code[7] ^ b) ? 8'hC1 : 8'h00);
    endfunction

    logic [4:0]  k_next;
    logic        island;
    logic        first;
    logic [23:0] hdr_sh;
    logic [6:0]  hdr_par;
    logic [7:0]  hdr_crc;
    logic [55:0] sub_sh  [4];
    logic [5:0]  sub_par [4];
    logic [7:0]  sub_crc [4];

    logic        start;
    logic        sync_err;
    logic        drop_err;
    logic [4:0]  k_cur;
    logic        first_cur;
    logic        done;
    logic        hdr_err_w;
    logic [3:0]  sub_err_w;
    logic        acr_ok;

    always_comb begin
        start     = i_data && !island;
        sync_err  = i_data && !i_d0[3] && !start && ((k_next != 5'd0) || !first);
        drop_err  = !i_data && island && (k_next != 5'd0);
        // A misplaced sync nibble restarts framing as a fresh first packet
        k_cur     = (start || sync_err) ? 5'd0 : k_next;
        first_cur = (start || sync_err) ? 1'b1 : first;
        done      = i_data && (k_cur == 5'd31);
        hdr_err_w = (hdr_crc != {hdr_par, i_d0[2]});
        sub_err_w = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            sub_err_w[n] = (sub_crc[n] != {sub_par[n], i_d1[n], i_d2[n]});
        end
        acr_ok    = (hdr_sh[7:0] == HDR_TYPE_ACR) &&
                    (!ACR_REQUIRE_ECC || (!hdr_err_w && !sub_err_w[0]));
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            k_next      <= 5'd0;
            island      <= 1'b0;
            first       <= 1'b0;
            hdr_sh      <= '0;
            hdr_par     <= '0;
            hdr_crc     <= '0;
            for (int n = 0; n < 4; n++) begin
                sub_sh[n]  <= '0;
                sub_par[n] <= '0;
                sub_crc[n] <= '0;
            end
            o_hSync     <= 1'b0;
            o_vSync     <= 1'b0;
            o_pkt_valid <= 1'b0;
            o_pkt_first <= 1'b0;
            o_hdr       <= '0;
            o_sub0      <= '0;
            o_sub1      <= '0;
            o_sub2      <= '0;
            o_sub3      <= '0;
            o_hdr_err   <= 1'b0;
            o_sub_err   <= '0;
            o_frame_err <= 1'b0;
            o_cts       <= '0;
            o_n         <= '0;
        end else begin
            island      <= i_data;
            o_pkt_valid <= done;
            o_frame_err <= sync_err || drop_err;
            if (i_data) begin
                o_hSync <= i_d0[0];
                o_vSync <= i_d0[1];
                k_next  <= k_cur + 5'd1;
                first   <= (k_cur == 5'd31) ? 1'b0 : first_cur;
                if (k_cur < 5'd24) begin
                    hdr_sh  <= {i_d0[2], hdr_sh[23:1]};
                    hdr_crc <= bch_step((k_cur == 5'd0) ? 8'h00 : hdr_crc, i_d0[2]);
                end else begin
                    hdr_par <= {hdr_par[5:0], i_d0[2]};
                end
                for (int n = 0; n < 4; n++) begin
                    if (k_cur < 5'd28) begin
                        sub_sh[n]  <= {i_d2[n], i_d1[n], sub_sh[n][55:2]};
                        sub_crc[n] <= bch_step(bch_step((k_cur == 5'd0) ? 8'h00 : sub_crc[n],
                                                        i_d1[n]), i_d2[n]);
                    end else begin
                        sub_par[n] <= {sub_par[n][3:0], i_d1[n], i_d2[n]};
                    end
                end
            end else begin
                k_next <= 5'd0;
            end
            if (done) begin
                o_pkt_first <= first_cur;
                o_hdr       <= hdr_sh;
                o_sub0      <= sub_sh[0];
                o_sub1      <= sub_sh[1];
                o_sub2      <= sub_sh[2];
                o_sub3      <= sub_sh[3];
                o_hdr_err   <= hdr_err_w;
                o_sub_err   <= sub_err_w;
                if (acr_ok) begin
                    o_cts <= {sub_sh[0][11:8], sub_sh[0][23:16], sub_sh[0][31:24]};
                    o_n   <= {sub_sh[0][35:32], sub_sh[0][47:40], sub_sh[0][55:48]};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_data_island_decoder.sv
// ============================================================================
// tb_hdmi_data_island_decoder: directed self-checking bench for the decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hdmi_data_island_decoder;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic        data   = 1'b0;
    logic [3:0]  d0 = '0, d1 = '0, d2 = '0;
    logic        hsync, vsync, pkt_valid, pkt_first, hdr_err, frame_err;
    logic [23:0] hdr;
    logic [55:0] sub0, sub1, sub2, sub3;
    logic [3:0]  sub_err;
    logic [19:0] cts, n_val;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int frame_cnt = 0;

    localparam logic [55:0] SUB_ACR  = 56'h00_18_00_78_69_00_00; // N=6144, CTS=27000
    localparam logic [55:0] SUB_ACR2 = 56'hCD_AB_F0_45_23_E1_00; // N=0x0ABCD, CTS=0x12345

    hdmi_data_island_decoder #(.ACR_REQUIRE_ECC(1'b1), .HDR_TYPE_ACR(8'h01)) dut (
        .i_pixclk(pixclk), .i_reset(reset), .i_data(data),
        .i_d0(d0), .i_d1(d1), .i_d2(d2),
        .o_hSync(hsync), .o_vSync(vsync), .o_pkt_valid(pkt_valid), .o_pkt_first(pkt_first),
        .o_hdr(hdr), .o_sub0(sub0), .o_sub1(sub1), .o_sub2(sub2), .o_sub3(sub3),
        .o_hdr_err(hdr_err), .o_sub_err(sub_err), .o_frame_err(frame_err),
        .o_cts(cts), .o_n(n_val)
    );

    always #5 pixclk = ~pixclk;

    always @(negedge pixclk) begin
        if (pkt_valid) valid_cnt <= valid_cnt + 1;
        if (frame_err) frame_cnt <= frame_cnt + 1;
    end

    function automatic logic [7:0] bch(input logic [55:0] v, input int nbits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < nbits; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ v[i]) ? 8'hC1 : 8'h00);
        return c;
    endfunction

    // hx corrupts header data after parity generation; px corrupts subpacket parity {s3,s2,s1,s0}
    task automatic send_packet(input logic [23:0] h_in, input logic [55:0] s0, s1, s2, s3,
                               input bit first, input logic [23:0] hx, input logic [31:0] px,
                               input int nbeats, input bit hs, input bit vs);
        logic [55:0] s [4];
        logic [7:0]  sp [4];
        logic [7:0]  hp;
        logic [23:0] h;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        hp = bch({32'h0, h_in}, 24);
        h  = h_in ^ hx;
        for (int n = 0; n < 4; n++) sp[n] = bch(s[n], 56) ^ px[8*n +: 8];
        for (int k = 0; k < nbeats; k++) begin
            data  = 1'b1;
            d0[0] = hs;
            d0[1] = vs;
            d0[2] = (k < 24) ? h[k] : hp[31-k];
            d0[3] = !(first && k == 0);
            for (int n = 0; n < 4; n++) begin
                if (k < 28) begin
                    d1[n] = s[n][2*k];
                    d2[n] = s[n][2*k+1];
                end else begin
                    d1[n] = sp[n][7-2*(k-28)];
                    d2[n] = sp[n][6-2*(k-28)];
                end
            end
            @(posedge pixclk); #1;
        end
    endtask

    task automatic idle(input int cycles);
        data = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        repeat (cycles) begin
            @(posedge pixclk); #1;
        end
    endtask

    task automatic test_reset;
        @(posedge pixclk); #1;
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pkt_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (hdr !== 24'h0) begin errors++; $display("FAIL reset_hdr: got %h want 0", hdr); end
        checks++; if (sub0 !== 56'h0) begin errors++; $display("FAIL reset_sub0: got %h want 0", sub0); end
        checks++; if (cts !== 20'h0 || n_val !== 20'h0) begin errors++; $display("FAIL reset_acr: got cts %h n %h want 0", cts, n_val); end
        checks++; if ({hsync, vsync, hdr_err, sub_err, pkt_first} !== 8'h0) begin errors++; $display("FAIL reset_misc: got %b want 0", {hsync, vsync, hdr_err, sub_err, pkt_first}); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_acr;
        int v0;
        v0 = valid_cnt;
        send_packet(24'h000001, SUB_ACR, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 32, 1'b1, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_first !== 1'b1) begin errors++; $display("FAIL acr_valid_first: got %b%b want 11", pkt_valid, pkt_first); end
        checks++; if (hdr_err !== 1'b0 || sub_err !== 4'b0) begin errors++; $display("FAIL acr_errs: got %b %b want 0 0000", hdr_err, sub_err); end
        checks++; if (hdr !== 24'h000001) begin errors++; $display("FAIL acr_hdr: got %h want 000001", hdr); end
        checks++; if (sub0 !== SUB_ACR) begin errors++; $display("FAIL acr_sub0: got %h want %h", sub0, SUB_ACR); end
        checks++; if (cts !== 20'd27000) begin errors++; $display("FAIL acr_cts: got %0d want 27000", cts); end
        checks++; if (n_val !== 20'd6144) begin errors++; $display("FAIL acr_n: got %0d want 6144", n_val); end
        idle(1);
        checks++; if (pkt_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL acr_after: got valid %b frame_err %b want 0 0", pkt_valid, frame_err); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b0) begin errors++; $display("FAIL acr_syncs: got %b%b want 10", hsync, vsync); end
        idle(1);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL acr_pulses: got %0d want 1", valid_cnt - v0); end
    endtask

    task automatic test_hdr_err;
        send_packet(24'h000001, SUB_ACR2, 56'h0, 56'h0, 56'h0, 1'b1, 24'h000020, 32'h0, 32, 1'b0, 1'b1);
        checks++; if (hdr_err !== 1'b1 || sub_err !== 4'b0) begin errors++; $display("FAIL hdr5_errs: got %b %b want 1 0000", hdr_err, sub_err); end
        checks++; if (hdr !== 24'h000021) begin errors++; $display("FAIL hdr5_hdr: got %h want 000021", hdr); end
        checks++; if (cts !== 20'd27000 || n_val !== 20'd6144) begin errors++; $display("FAIL hdr5_acr: got %0d %0d want 27000 6144", cts, n_val); end
        checks++; if (vsync !== 1'b1 || hsync !== 1'b0) begin errors++; $display("FAIL hdr5_syncs: got %b%b want 01", hsync, vsync); end
        idle(2);
        send_packet(24'h000001, SUB_ACR2, 56'h0, 56'h0, 56'h0, 1'b1, 24'h001000, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (hdr_err !== 1'b1 || hdr !== 24'h001001) begin errors++; $display("FAIL hdr12: got err %b hdr %h want 1 001001", hdr_err, hdr); end
        checks++; if (cts !== 20'd27000 || n_val !== 20'd6144) begin errors++; $display("FAIL hdr12_acr: got %0d %0d want 27000 6144", cts, n_val); end
        idle(2);
        send_packet(24'h000001, SUB_ACR2, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h00000001, 32, 1'b0, 1'b0);
        checks++; if (hdr_err !== 1'b0 || sub_err !== 4'b0001) begin errors++; $display("FAIL sub0par_errs: got %b %b want 0 0001", hdr_err, sub_err); end
        checks++; if (cts !== 20'd27000 || n_val !== 20'd6144) begin errors++; $display("FAIL sub0par_acr: got %0d %0d want 27000 6144", cts, n_val); end
        idle(2);
        send_packet(24'h000001, SUB_ACR2, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (cts !== 20'h12345 || n_val !== 20'h0ABCD) begin errors++; $display("FAIL acr2: got %h %h want 12345 0abcd", cts, n_val); end
        idle(2);
    endtask

    task automatic test_sub_err;
        send_packet(24'h0D0282, 56'h11223344556677, 56'h8899AABBCCDDEE, 56'h0F1E2D3C4B5A69,
                    56'hF0E1D2C3B4A596, 1'b1, 24'h0, 32'h00080000, 32, 1'b0, 1'b0);
        checks++; if (hdr_err !== 1'b0 || sub_err !== 4'b0100) begin errors++; $display("FAIL avi_errs: got %b %b want 0 0100", hdr_err, sub_err); end
        checks++; if (hdr !== 24'h0D0282) begin errors++; $display("FAIL avi_hdr: got %h want 0d0282", hdr); end
        checks++; if (sub1 !== 56'h8899AABBCCDDEE || sub2 !== 56'h0F1E2D3C4B5A69 || sub3 !== 56'hF0E1D2C3B4A596)
            begin errors++; $display("FAIL avi_subs: got %h %h %h", sub1, sub2, sub3); end
        checks++; if (cts !== 20'h12345) begin errors++; $display("FAIL avi_cts: got %h want 12345", cts); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int v0, f0;
        v0 = valid_cnt; f0 = frame_cnt;
        send_packet(24'h0A0B0C, 56'h1, 56'h2, 56'h3, 56'h4, 1'b1, 24'h0, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_first !== 1'b1 || hdr !== 24'h0A0B0C) begin errors++; $display("FAIL b2b_first: got %b%b %h want 11 0a0b0c", pkt_valid, pkt_first, hdr); end
        send_packet(24'h112233, 56'h5, 56'h6, 56'h7, 56'h8, 1'b0, 24'h0, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_first !== 1'b0 || hdr !== 24'h112233) begin errors++; $display("FAIL b2b_second: got %b%b %h want 10 112233", pkt_valid, pkt_first, hdr); end
        checks++; if (hdr_err !== 1'b0 || sub_err !== 4'b0 || sub3 !== 56'h8) begin errors++; $display("FAIL b2b_errs: got %b %b %h", hdr_err, sub_err, sub3); end
        idle(1);
        checks++; if (valid_cnt - v0 !== 2 || frame_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_pulses: got %0d %0d want 2 0", valid_cnt - v0, frame_cnt - f0); end
        idle(1);
    endtask

    task automatic test_sync_err;
        int f0;
        f0 = frame_cnt;
        send_packet(24'h0000AA, 56'h0, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 10, 1'b0, 1'b0);
        send_packet(24'h0000BB, 56'h9, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_first !== 1'b1 || hdr !== 24'h0000BB || hdr_err !== 1'b0)
            begin errors++; $display("FAIL sync_pkt: got %b%b %h %b want 11 0000bb 0", pkt_valid, pkt_first, hdr, hdr_err); end
        checks++; if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL sync_frame_err: got %0d want 1", frame_cnt - f0); end
        idle(2);
    endtask

    task automatic test_drop;
        int v0, f0;
        v0 = valid_cnt; f0 = frame_cnt;
        send_packet(24'h0000CC, 56'h0, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 15, 1'b0, 1'b0);
        idle(1);
        checks++; if (frame_err !== 1'b1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL drop_pulse: got frame_err %b valid %b want 1 0", frame_err, pkt_valid); end
        idle(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL drop_once: got %b want 0", frame_err); end
        send_packet(24'h0000DD, 56'h0, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || hdr !== 24'h0000DD || hdr_err !== 1'b0 || sub_err !== 4'b0)
            begin errors++; $display("FAIL drop_next: got %b %h %b %b want 1 0000dd 0 0000", pkt_valid, hdr, hdr_err, sub_err); end
        idle(2);
        checks++; if (valid_cnt - v0 !== 1 || frame_cnt - f0 !== 1) begin errors++; $display("FAIL drop_counts: got %0d %0d want 1 1", valid_cnt - v0, frame_cnt - f0); end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        send_packet(24'h000001, SUB_ACR2, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 20, 1'b1, 1'b1);
        v0 = valid_cnt; f0 = frame_cnt;
        #2 reset = 1'b1;
        #1;
        checks++; if (cts !== 20'h0 || n_val !== 20'h0 || hdr !== 24'h0 || sub0 !== 56'h0)
            begin errors++; $display("FAIL rstmid_regs: got %h %h %h %h want 0", cts, n_val, hdr, sub0); end
        checks++; if (hsync !== 1'b0 || vsync !== 1'b0 || pkt_valid !== 1'b0)
            begin errors++; $display("FAIL rstmid_flags: got %b%b%b want 000", hsync, vsync, pkt_valid); end
        @(posedge pixclk); #1;
        @(posedge pixclk); #1;
        data = 1'b0;
        reset = 1'b0;
        idle(2);
        send_packet(24'h000001, SUB_ACR, 56'h0, 56'h0, 56'h0, 1'b1, 24'h0, 32'h0, 32, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1 || pkt_first !== 1'b1 || hdr_err !== 1'b0 || sub_err !== 4'b0)
            begin errors++; $display("FAIL rstmid_pkt: got %b%b %b %b want 11 0 0000", pkt_valid, pkt_first, hdr_err, sub_err); end
        checks++; if (cts !== 20'd27000 || n_val !== 20'd6144) begin errors++; $display("FAIL rstmid_acr: got %0d %0d want 27000 6144", cts, n_val); end
        idle(2);
        checks++; if (valid_cnt - v0 !== 1 || frame_cnt - f0 !== 0) begin errors++; $display("FAIL rstmid_counts: got %0d %0d want 1 0", valid_cnt - v0, frame_cnt - f0); end
    endtask

    initial begin
        test_reset;
        test_acr;
        test_hdr_err;
        test_sub_err;
        test_back_to_back;
        test_sync_err;
        test_drop;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hdmi_data_island_decoder.md
Name: hdmi_data_island_decoder

Overview:
Receive-side counterpart of the HDMI data-island packet encoder. It takes TERC4-decoded 4-bit nibbles from channels 0/1/2 during data-island periods and reassembles each 32-clock packet into a 24-bit header and four 56-bit subpackets. It checks the BCH(32,24) and BCH(64,56) parity, recovers HSYNC/VSYNC, and latches Audio Clock Regeneration (ACR) CTS/N values. It sits after the TMDS/TERC4 decode stage in the HDMI receive/loopback test path.

Parameters:
ACR_REQUIRE_ECC, 1, when 1, o_cts/o_n update only if the header and subpacket 0 both pass ECC; when 0, they update on any type-0x01 packet.
HDR_TYPE_ACR, 8'h01, header byte 0 value that identifies an ACR packet.

Ports:
i_pixclk  in  1  pixel clock; all logic is on the rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_data  in  1  high while the current clock carries data-island TERC4 nibbles.
i_d0  in  4  channel 0 nibble: [0]=HSYNC, [1]=VSYNC, [2]=header bit, [3]=0 only on clock 0 of the first packet.
i_d1  in  4  channel 1 nibble: bit n = even bit of subpacket n.
i_d2  in  4  channel 2 nibble: bit n = odd bit of subpacket n.
o_hSync  out  1  i_d0[0], registered while i_data=1; holds its value otherwise.
o_vSync  out  1  i_d0[1], same rule as o_hSync.
o_pkt_valid  out  1  one-cycle pulse when a complete packet is presented.
o_pkt_first  out  1  packet was the first packet of its data island; qualified by o_pkt_valid.
o_hdr  out  24  packet header, HB0 in [7:0].
o_sub0, o_sub1, o_sub2, o_sub3  out  56 each  subpackets, SB0 in [7:0].
o_hdr_err  out  1  header BCH mismatch; qualified by o_pkt_valid.
o_sub_err  out  4  per-subpacket BCH mismatch; qualified by o_pkt_valid.
o_frame_err  out  1  one-cycle pulse when a packet is aborted.
o_cts  out  20  last accepted ACR CTS value.
o_n  out  20  last accepted ACR N value.

Behaviour:
- Reset: every output, the bit counter, the shift registers, the ECC LFSRs and the first-flag clear to 0. Asynchronous assertion takes effect immediately; a packet in flight at reset is discarded without any pulse.
- Bit counter k runs 0..31 and advances only while i_data=1.
  - On a 0→1 transition of i_data, the current clock is k=0 and the first-flag is set.
  - After k=31 the next clock is k=0 of the next packet, with the first-flag cleared.
- Header assembly:
  - k=0..23: i_d0[2] is header bit k and is fed into the header LFSR.
  - k=24..31: i_d0[2] is parity, shifted in MSB-first.
- Subpacket n assembly:
  - k=0..27: i_d1[n] is bit 2k and i_d2[n] is bit 2k+1; both feed the subpacket-n LFSR, even bit first.
  - k=28..31: i_d1[n] and i_d2[n] are parity, MSB-first pairs (i_d1[n] is the more significant bit of each pair).
- LFSR definition: per data bit b, code = (code<<1) ^ ((code[7]^b) ? 8'hC1 : 0). Each LFSR clears at k=0.
  - Header check: computed code after 24 bits must equal the 8 received parity bits.
  - Subpacket check: computed code after 56 bits must equal the 8 received parity bits.
- Completion: the clock after k=31, the block pulses o_pkt_valid for 1 cycle.
  - o_hdr, o_sub0..3, o_hdr_err, o_sub_err and o_pkt_first update in that same cycle and hold until the next packet.
  - Latency is 1 clock from the last nibble.
- Framing:
  - i_data 0 at 1≤k≤31: abort the packet, pulse o_frame_err, reset k, no o_pkt_valid.
  - i_d0[3]=0 while i_data=1 and (k≠0 or first-flag=0): abort the packet and pulse o_frame_err. That clock is taken as k=0 of a new first packet.
  - i_d0[3]=1 at k=0 of a first packet: accepted, no error.
  - Back-to-back packets within one island produce no gap cycles.
- ACR capture: when a completed packet has o_hdr[7:0]==HDR_TYPE_ACR and passes the ACR_REQUIRE_ECC rule, the block updates, in the o_pkt_valid cycle:
  - o_cts = {sub0[11:8], sub0[23:16], sub0[31:24]}
  - o_n = {sub0[35:32], sub0[47:40], sub0[55:48]}
  - A failing ACR packet leaves o_cts and o_n unchanged.
- Simultaneous completion and new packet start: the completion outputs reflect the finished packet; the new packet's k=0 nibble is captured normally.

Test Plan:
- Reset, then one ACR packet: header 24'h000001, sub0={6144,27000 fields}, sub1..3=0, correct parity, i_d0[3]=0 at k=0 → o_pkt_valid pulses 1 clk after k=31; o_pkt_first=1, errors=0, o_cts=27000, o_n=6144.
- Same packet with header bit 5 flipped → o_hdr_err=1, o_sub_err=4'b0000; with ACR_REQUIRE_ECC=1, o_cts/o_n unchanged from the previous values.
- AVI infoframe header 24'h0D0282 with sub2 parity bit 3 flipped → o_sub_err=4'b0100, o_hdr_err=0, o_hdr=24'h0D0282.
- Two back-to-back packets in one 64-clock island → two o_pkt_valid pulses 32 clocks apart; o_pkt_first=1 then 0.
- i_data dropped at k=15 → o_frame_err pulses once, no o_pkt_valid; the next island decodes cleanly.
- i_reset asserted at k=20 → all outputs 0 immediately; after release, a clean packet decodes with errors=0.
